// File: rtl/defs.sv
// rtl/defs.sv - shared definitions for the vector load/store OBI master
package defs;

  localparam int OBI_ADDR_W = 32;
  localparam int OBI_DATA_W = 32;
  localparam int VREG_W     = 128;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } vlsu_state_t;

  // Bytes touched by a unit-stride command; vsew 11 behaves as 32-bit, total capped at one vector register.
  function automatic logic [4:0] calc_nbytes(input logic [4:0] vl, input logic [1:0] vsew);
    logic [1:0] sh;
    logic [6:0] raw;
    sh  = (vsew == 2'b11) ? 2'b10 : vsew;
    raw = {2'b00, vl} << sh;
    return (raw > 7'd16) ? 5'd16 : raw[4:0];
  endfunction

endpackage

// File: rtl/vlsu_be_gen.sv
// rtl/vlsu_be_gen.sv - byte enables for one OBI beat of a vector access
module vlsu_be_gen (
  input  logic [2:0] beat,
  input  logic [4:0] nbytes,
  output logic [3:0] be
);

  logic [5:0] base;
  logic [5:0] rem;

  always_comb begin
    base = {1'b0, beat, 2'b00};
    rem  = {1'b0, nbytes} - base;
    be   = 4'h0;
    if ({1'b0, nbytes} > base) begin
      if (rem >= 6'd4) begin
        be = 4'hF;
      end else begin
        case (rem[1:0])
          2'd1:    be = 4'h1;
          2'd2:    be = 4'h3;
          2'd3:    be = 4'h7;
          default: be = 4'h0;
        endcase
      end
    end
  end

endmodule

// File: rtl/vlsu_obi_master.sv
// rtl/vlsu_obi_master.sv - pipelined OBI initiator for unit-stride vector loads and stores
module vlsu_obi_master
  import defs::*;
#(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_store,
  input  logic [OBI_ADDR_W-1:0] cmd_addr,
  input  logic [4:0]            cmd_vl,
  input  logic [1:0]            cmd_vsew,
  input  logic [VREG_W-1:0]     cmd_wdata,
  output logic                  obi_req,
  input  logic                  obi_gnt,
  output logic [OBI_ADDR_W-1:0] obi_addr,
  output logic                  obi_we,
  output logic [3:0]            obi_be,
  output logic [OBI_DATA_W-1:0] obi_wdata,
  input  logic                  obi_rvalid,
  input  logic [OBI_DATA_W-1:0] obi_rdata,
  input  logic                  obi_err,
  output logic [VREG_W-1:0]     ld_data,
  output logic [15:0]           ld_byte_en,
  output logic                  ld_valid,
  output logic                  done,
  output logic                  err
);

  vlsu_state_t state_q, state_d;

  logic                  store_q;
  logic [OBI_ADDR_W-1:0] base_q;
  logic [VREG_W-1:0]     wdata_q;
  logic [4:0]            nbytes_q;
  logic [2:0]            nbeats_q;
  logic                  err_q;
  logic [2:0]            out_cnt;
  logic [2:0]            issue_cnt;
  logic [2:0]            rsp_cnt;

  logic                  req_d;
  logic [OBI_ADDR_W-1:0] addr_d;
  logic                  we_d;
  logic [3:0]            be_d;
  logic [OBI_DATA_W-1:0] wdata_d;

  logic       accept;
  logic [4:0] nbytes_in;
  logic [4:0] nbeats_sum;
  logic [2:0] nbeats_in;
  logic       misaligned;
  logic       gnt_fire;
  logic       rsp_fire;
  logic [2:0] out_next;
  logic [2:0] issue_next;
  logic [2:0] rsp_next;
  logic [2:0] be_beat;
  logic [4:0] be_nbytes;
  logic [3:0] be_nxt;

  assign accept     = cmd_valid && (state_q == IDLE);
  assign nbytes_in  = calc_nbytes(cmd_vl, cmd_vsew);
  assign nbeats_sum = nbytes_in + 5'd3;
  assign nbeats_in  = nbeats_sum[4:2];
  assign misaligned = (cmd_addr[1:0] != 2'b00);

  // Responses with nothing outstanding are stray and must not disturb the counters.
  assign gnt_fire   = obi_req && obi_gnt;
  assign rsp_fire   = obi_rvalid && (out_cnt != 3'd0);
  assign out_next   = out_cnt + {2'b00, gnt_fire} - {2'b00, rsp_fire};
  assign issue_next = issue_cnt + {2'b00, gnt_fire};
  assign rsp_next   = rsp_cnt + {2'b00, rsp_fire};

  assign be_beat    = accept ? 3'd0 : issue_next;
  assign be_nbytes  = accept ? nbytes_in : nbytes_q;

  vlsu_be_gen u_be_gen (
    .beat   (be_beat),
    .nbytes (be_nbytes),
    .be     (be_nxt)
  );

  assign cmd_ready = (state_q == IDLE);
  assign done      = (state_q == DONE);
  assign err       = done && err_q;
  assign ld_valid  = done && !store_q;

  always_comb begin
    state_d = state_q;
    req_d   = 1'b0;
    addr_d  = obi_addr;
    we_d    = obi_we;
    be_d    = obi_be;
    wdata_d = obi_wdata;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (nbeats_in == 3'd0 || misaligned) begin
            state_d = DONE;
          end else begin
            state_d = ISSUE;
            req_d   = 1'b1;
            addr_d  = cmd_addr;
            we_d    = cmd_store;
            be_d    = be_nxt;
            wdata_d = cmd_wdata[OBI_DATA_W-1:0];
          end
        end
      end
      ISSUE: begin
        // A raised request is frozen until granted; the next beat is prepared only after that.
        if (obi_req && !obi_gnt) begin
          req_d = 1'b1;
        end else if (issue_next < nbeats_q && 32'(out_next) < MAX_OUTSTANDING) begin
          req_d   = 1'b1;
          addr_d  = base_q + {27'd0, issue_next, 2'b00};
          be_d    = be_nxt;
          wdata_d = wdata_q[{issue_next[1:0], 5'd0} +: OBI_DATA_W];
        end
        if (gnt_fire && issue_next == nbeats_q) state_d = DRAIN;
      end
      DRAIN: begin
        if (rsp_next >= nbeats_q) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q    <= IDLE;
      obi_req    <= 1'b0;
      obi_addr   <= '0;
      obi_we     <= 1'b0;
      obi_be     <= 4'h0;
      obi_wdata  <= '0;
      store_q    <= 1'b0;
      base_q     <= '0;
      wdata_q    <= '0;
      nbytes_q   <= 5'd0;
      nbeats_q   <= 3'd0;
      err_q      <= 1'b0;
      out_cnt    <= 3'd0;
      issue_cnt  <= 3'd0;
      rsp_cnt    <= 3'd0;
      ld_data    <= '0;
      ld_byte_en <= 16'h0;
    end else begin
      state_q   <= state_d;
      obi_req   <= req_d;
      obi_addr  <= addr_d;
      obi_we    <= we_d;
      obi_be    <= be_d;
      obi_wdata <= wdata_d;
      out_cnt   <= out_next;
      if (accept) begin
        store_q    <= cmd_store;
        base_q     <= cmd_addr;
        wdata_q    <= cmd_wdata;
        nbytes_q   <= nbytes_in;
        nbeats_q   <= nbeats_in;
        err_q      <= misaligned;
        issue_cnt  <= 3'd0;
        rsp_cnt    <= 3'd0;
        ld_data    <= '0;
        ld_byte_en <= cmd_store ? 16'h0 : ~(16'hFFFF << nbytes_in);
      end else begin
        issue_cnt <= issue_next;
        if (rsp_fire) begin
          rsp_cnt <= rsp_next;
          if (obi_err) err_q <= 1'b1;
          if (!store_q && rsp_cnt < 3'd4) ld_data[{rsp_cnt[1:0], 5'd0} +: OBI_DATA_W] <= obi_rdata;
        end
      end
    end
  end

endmodule

// File: doc/vlsu_obi_master.md
# vlsu_obi_master

Vector load/store unit OBI initiator for the accelerator. It accepts one unit-stride vector load or store command per vector register from the decode/issue path and performs the data-memory transactions as a pipelined OBI master. Load data is packed into a 128-bit vector-register write with per-byte enables; store data is taken from a 128-bit vector-register read. It sits between the vector decoder/register file and the core's shared data-memory OBI port.

## Interface
- `MAX_OUTSTANDING`, default 2: maximum number of granted OBI requests awaiting `rvalid`, range 1..4.
- `clk` input 1: clock.
- `n_reset` input 1: asynchronous, active-low reset.
- `cmd_valid` input 1: command offered.
- `cmd_ready` output 1: high only in IDLE.
- `cmd_store` input 1: 1 = store, 0 = load.
- `cmd_addr` input 32: base byte address; must be word aligned.
- `cmd_vl` input 5: element count, 0..16.
- `cmd_vsew` input 2: element width; 00 = 8-bit, 01 = 16-bit, 10 = 32-bit; 11 is reserved and treated as 10.
- `cmd_wdata` input 128: store data, captured on accept.
- `obi_req` output 1: OBI request.
- `obi_gnt` input 1: OBI grant.
- `obi_addr` output 32: request address.
- `obi_we` output 1: write enable.
- `obi_be` output 4: byte enables.
- `obi_wdata` output 32: write data.
- `obi_rvalid` input 1: response valid.
- `obi_rdata` input 32: read data.
- `obi_err` input 1: response error.
- `ld_data` output 128: packed load result; bytes not loaded are 0.
- `ld_byte_en` output 16: bytes of `ld_data` to write into vd.
- `ld_valid` output 1: one-cycle pulse, load results valid.
- `done` output 1: one-cycle pulse, command complete (load or store).
- `err` output 1: qualified by `done`; bus error or misaligned address.

## Operation
- The block is idle with `cmd_ready`=1; a command is accepted when `cmd_valid`&&`cmd_ready`.
- On accept, the block latches `cmd_store`, `cmd_addr`, `cmd_wdata` and the total byte count `nbytes` = `cmd_vl` << `cmd_vsew`, saturated at 16.
- The beat count is `nbeats` = ceil(`nbytes`/4), giving 0..4 beats.
- Beat k uses:
  - address `cmd_addr` + 4k;
  - `obi_wdata` = `cmd_wdata`[32k+31:32k];
  - `obi_be` = 4'hF, except on the last beat, where it is (1<<(`nbytes`-4k))-1 when `nbytes` is not a multiple of 4.
- The state machine has four states:
  - IDLE → ISSUE on accept when `nbeats`>0 and the address is aligned.
  - IDLE → DONE on accept when `nbeats`=0 or `cmd_addr`[1:0]≠0. No OBI traffic occurs; `err`=1 if misaligned.
  - ISSUE → DRAIN once the final beat is granted.
  - DRAIN → DONE once the response count equals `nbeats`.
  - DONE → IDLE unconditionally.
- Issue rules:
  - `obi_req` is asserted in ISSUE only when outstanding < `MAX_OUTSTANDING`, or when a response arrives in the same cycle.
  - Once `obi_req` is raised, `obi_req`, `obi_addr`, `obi_we`, `obi_be` and `obi_wdata` are held stable until `obi_gnt`.
- Outstanding counter: increments on `obi_req`&&`obi_gnt`, decrements on `obi_rvalid`; both in one cycle leave it unchanged.
- Responses return in order. A response counter indexes load-word placement: `obi_rdata` is written to `ld_data`[32r+31:32r].
- An `obi_rvalid` that arrives while outstanding = 0 is ignored.
- Any `obi_err` during a command sets a sticky error. That error is reported on `done` and cleared on the next accept; the remaining beats still complete.
- `ld_byte_en` bit i = (i < `nbytes`) for loads and is 0 for stores. `ld_valid` pulses together with `done` for loads only.
- `ld_data` is cleared to 0 on each accept.

## Timing
- Reset values:
  - `obi_req`=0, `obi_we`=0, `obi_be`=0, `obi_addr`=0, `obi_wdata`=0;
  - `ld_data`=0, `ld_byte_en`=0, `ld_valid`=0, `done`=0, `err`=0;
  - `cmd_ready`=1; state IDLE; all counters 0.
- Accept in cycle 0 → first `obi_req` in cycle 1, driven from registers.
- With zero-wait grant and single-cycle `rvalid`, N beats issue in cycles 1..N, and `done` pulses in cycle N+2.
- For `vl`=0 or a misaligned address, `done` pulses in cycle 1.
- `done` and `ld_valid` fire the cycle after the final `rvalid`.
- `ld_data` and `ld_byte_en` hold their values until the next accept.
- `n_reset` asserted mid-command drops `obi_req` immediately and returns to IDLE, with no `done`.

## Structure
- Shared `defs.sv` package gains:
  - the `vlsu_state_t` enum (IDLE, ISSUE, DRAIN, DONE);
  - constants `OBI_ADDR_W`=32, `OBI_DATA_W`=32, `VREG_W`=128.
- One combinational sub-module, `vlsu_be_gen`, maps (beat index, `nbytes`) to `obi_be`. The state machine, counters and packing remain in the top of this block.

## Test plan
- Load, `vl`=4, `vsew`=10, addr 0x100, immediate `gnt`, `rvalid` one cycle later, rdata 0x11111111…0x44444444 → addresses 0x100, 0x104, 0x108, 0x10C; `ld_data`=0x44444444_33333333_22222222_11111111; `ld_byte_en`=0xFFFF; `done` in cycle 6.
- Store, `vl`=5, `vsew`=00, addr 0x200, `cmd_wdata`[39:0]=0xAA_DDCCBBAA → two beats with `be` 0xF then 0x1; wdata 0xDDCCBBAA then 0x000000AA; `obi_we`=1; `ld_valid` stays 0.
- Grant held low for 3 cycles on beat 1 → `obi_addr`, `be` and `wdata` remain stable, and outstanding never exceeds 2 with `rvalid` delayed 5 cycles.
- `vl`=0, and separately addr 0x102 → no `obi_req`; `done` in cycle 1 with `err`=0 and `err`=1 respectively.
- `obi_err`=1 on beat 2 of a 4-beat load → all 4 beats complete; `done` arrives with `err`=1; the next command reports `err`=0.
- `n_reset` pulsed low during DRAIN → outputs reset in the same cycle; `cmd_ready`=1; a subsequent load completes correctly.
